// File: rtl/mdl_sdrdseq_pkg.sv
// Shared types and sizing helpers for the SD card-side read-block sequencer.
package mdl_sdrdseq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_NAC  = 3'd1,
      ST_SEND = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int WORD_W = 32;
   localparam int FIFO_W = WORD_W + 1;

   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } fifo_word_t;

   function automatic int words_per_block(input int lgblk);
      return 1 << (lgblk - 2);
   endfunction

   // NAC and GAP share one down-the-line counter, sized for the larger wait.
   function automatic int delay_cnt_w(input int nac, input int gap);
      return $clog2((nac > gap) ? nac : gap) + 1;
   endfunction

endpackage

// File: rtl/mdl_sdrdseq_if.sv
// Command, memory and transmitter signals of the read-block sequencer.
interface mdl_sdrdseq_if #(
   parameter int AW = 16
);
   import mdl_sdrdseq_pkg::*;

   logic          i_cmd_stb;
   logic [AW-1:0] i_cmd_addr;
   logic [15:0]   i_cmd_nblk;
   logic          i_stop;
   logic          o_busy;
   logic          o_done;
   logic [15:0]   o_blk_count;
   logic          o_mem_rd;
   logic [AW-1:0] o_mem_addr;
   logic [31:0]   i_mem_data;
   logic          o_tx_en;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic [31:0]   o_tx_data;
   logic          o_tx_last;
   state_t        o_dbg_state;

   // Transmit handshake: a word moves on the falling sd_clk edge where
   // o_tx_valid && i_tx_ready; while o_tx_valid && !i_tx_ready the sequencer
   // holds o_tx_data/o_tx_last and keeps o_tx_valid high (only a stop drops it).
   modport slave (
      input  i_cmd_stb, i_cmd_addr, i_cmd_nblk, i_stop, i_mem_data, i_tx_ready,
      output o_busy, o_done, o_blk_count, o_mem_rd, o_mem_addr,
      output o_tx_en, o_tx_valid, o_tx_data, o_tx_last, o_dbg_state
   );

   modport master (
      output i_cmd_stb, i_cmd_addr, i_cmd_nblk, i_stop, i_mem_data, i_tx_ready,
      input  o_busy, o_done, o_blk_count, o_mem_rd, o_mem_addr,
      input  o_tx_en, o_tx_valid, o_tx_data, o_tx_last, o_dbg_state
   );

endinterface

// File: rtl/mdl_sdrdseq_wordfifo.sv
// Two-entry {last,data} word FIFO on the falling sd_clk edge, with synchronous flush.
module mdl_sdrdseq_wordfifo
   import mdl_sdrdseq_pkg::*;
(
   input  logic       sd_clk,
   input  logic       rst_n,
   input  logic       i_flush,
   input  logic       i_push,
   input  fifo_word_t i_data,
   input  logic       i_pop,
   output fifo_word_t o_head,
   output logic       o_empty,
   output logic [1:0] o_count
);

   fifo_word_t r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_do_push;
   logic       w_do_pop;

   // A push into a full FIFO is accepted only when the head leaves on the same edge.
   assign w_do_pop  = i_pop && (r_count != 2'd0);
   assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

   always_ff @(negedge sd_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/mdl_sdrdseq.sv
// Card-side read sequencer: prefetches block words from memory and streams them
// to the SD data transmitter with NAC access delay, inter-block gaps and stop.
module mdl_sdrdseq
   import mdl_sdrdseq_pkg::*;
#(
   parameter int AW    = 16,
   parameter int LGBLK = 9,
   parameter int NAC   = 8,
   parameter int GAP   = 64
) (
   input  logic          sd_clk,
   input  logic          rst_n,
   mdl_sdrdseq_if.slave  bus
);

   localparam int WPB = words_per_block(LGBLK);
   localparam int CW  = delay_cnt_w(NAC, GAP);
   localparam int RW  = $clog2(WPB) + 1;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_req;
   logic [AW-1:0] r_addr;
   logic [15:0]   r_nblk;
   logic [15:0]   r_blk_count;
   logic          r_mem_rd;
   logic          r_rd_last;
   logic          r_inflight;
   logic          r_infl_last;
   logic          r_tx_en;
   logic          r_done;

   fifo_word_t    w_head;
   fifo_word_t    w_push_word;
   logic          w_empty;
   logic [1:0]    w_count;
   logic          w_valid;
   logic          w_hs;
   logic          w_stop;
   logic          w_push;
   logic [2:0]    w_committed;
   logic          w_issue;

   // DONE is already on its way back to IDLE with o_done high, so stop is not re-taken there.
   assign w_stop  = bus.i_stop &&
                    ((r_state == ST_NAC) || (r_state == ST_SEND) || (r_state == ST_GAP));
   assign w_valid = (r_state == ST_SEND) && !w_empty;
   assign w_hs    = w_valid && bus.i_tx_ready && !bus.i_stop;
   assign w_push  = r_inflight && !w_stop;

   // Words the FIFO is committed to hold after this edge, before any new read.
   assign w_committed = {1'b0, w_count} + {2'b00, r_inflight} + {2'b00, r_mem_rd}
                        - {2'b00, w_hs};
   assign w_issue     = ((r_state == ST_NAC) || (r_state == ST_SEND)) && !bus.i_stop &&
                        (r_req < RW'(WPB)) && (w_committed < 3'd2);

   assign w_push_word.last = r_infl_last;
   assign w_push_word.data = bus.i_mem_data;

   mdl_sdrdseq_wordfifo u_fifo (
      .sd_clk  (sd_clk),
      .rst_n   (rst_n),
      .i_flush (w_stop),
      .i_push  (w_push),
      .i_data  (w_push_word),
      .i_pop   (w_hs),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(negedge sd_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_req       <= '0;
         r_addr      <= '0;
         r_nblk      <= '0;
         r_blk_count <= '0;
         r_mem_rd    <= 1'b0;
         r_rd_last   <= 1'b0;
         r_inflight  <= 1'b0;
         r_infl_last <= 1'b0;
         r_tx_en     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_inflight  <= r_mem_rd;
         r_infl_last <= r_rd_last;
         r_mem_rd    <= w_issue;
         r_rd_last   <= w_issue && (r_req == RW'(WPB - 1));
         if (r_mem_rd) begin
            r_addr <= r_addr + AW'(1);
         end
         if (w_issue) begin
            r_req <= r_req + RW'(1);
         end

         if (w_stop) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_tx_en    <= 1'b0;
            r_done     <= 1'b1;
            r_mem_rd   <= 1'b0;
            r_inflight <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.i_cmd_stb && !bus.i_stop) begin
                     r_addr      <= bus.i_cmd_addr;
                     r_nblk      <= bus.i_cmd_nblk;
                     r_blk_count <= '0;
                     r_tx_en     <= 1'b1;
                     r_cnt       <= '0;
                     r_req       <= '0;
                     r_state     <= ST_NAC;
                  end
               end
               ST_NAC: begin
                  if (r_cnt == CW'(NAC - 1)) begin
                     r_cnt   <= '0;
                     r_state <= ST_SEND;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               ST_SEND: begin
                  if (w_hs && w_head.last) begin
                     if (r_blk_count != 16'hffff) begin
                        r_blk_count <= r_blk_count + 16'd1;
                     end
                     r_cnt   <= '0;
                     r_state <= ST_GAP;
                  end
               end
               ST_GAP: begin
                  if (r_cnt == CW'(GAP - 1)) begin
                     r_cnt <= '0;
                     if ((r_nblk != 16'd0) && (r_blk_count == r_nblk)) begin
                        r_tx_en <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                     end else begin
                        r_req   <= '0;
                        r_state <= ST_NAC;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               ST_DONE: begin
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.o_busy      = (r_state != ST_IDLE);
   assign bus.o_done      = r_done;
   assign bus.o_blk_count = r_blk_count;
   assign bus.o_mem_rd    = r_mem_rd;
   assign bus.o_mem_addr  = r_addr;
   assign bus.o_tx_en     = r_tx_en;
   assign bus.o_tx_valid  = w_valid;
   assign bus.o_tx_data   = w_head.data;
   assign bus.o_tx_last   = w_valid && w_head.last;
   assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_mdl_sdrdseq.sv
// Directed scoreboard bench for mdl_sdrdseq: word stream, timing, wrap, stop and reset.
module tb_mdl_sdrdseq;
   import mdl_sdrdseq_pkg::*;

   localparam int AW    = 16;
   localparam int LGBLK = 9;
   localparam int WPB   = 128;
   localparam int NAC   = 8;
   localparam int GAP   = 64;

   logic        sd_clk = 1'b0;
   logic        rst_n;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          hs_count = 0;
   int          rd_count = 0;
   int          done_count = 0;
   logic [32:0] exp_q[$];
   bit          throttle = 1'b0;
   int          acc_neg = 0;
   int          last_neg = 0;
   bit          pending_nac = 1'b0;
   bit          pending_gap = 1'b0;
   bit          hold_chk = 1'b0;
   logic [32:0] hold_word;
   logic        mem_rd_s = 1'b0;
   logic [15:0] mem_addr_s = '0;

   mdl_sdrdseq_if #(.AW(AW)) bus ();

   mdl_sdrdseq #(.AW(AW), .LGBLK(LGBLK), .NAC(NAC), .GAP(GAP)) dut (
      .sd_clk (sd_clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 sd_clk = ~sd_clk;
   always @(negedge sd_clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- models driving DUT inputs ----------------
   // Backing memory holds mem[a] = a; data appears one cycle after the read strobe.
   always @(posedge sd_clk) begin
      mem_rd_s   = bus.o_mem_rd;
      mem_addr_s = bus.o_mem_addr;
   end

   always @(negedge sd_clk) begin
      #1;
      bus.i_mem_data = mem_rd_s ? {16'h0000, mem_addr_s} : 32'hDEAD_BEEF;
   end

   always @(posedge sd_clk) begin
      #1;
      bus.i_tx_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge sd_clk) begin
      #2;
      if (rst_n) begin
         if (bus.o_mem_rd) rd_count++;
         if (bus.o_done) done_count++;
         if (bus.i_cmd_stb && !bus.i_stop && !bus.o_busy) begin
            acc_neg     = cyc + 1;
            pending_nac = 1'b1;
            pending_gap = 1'b0;
         end
         if (bus.o_tx_valid && pending_nac) begin
            chk("nac_latency", 64'(cyc - acc_neg), 64'(NAC));
            pending_nac = 1'b0;
         end else if (bus.o_tx_valid && pending_gap) begin
            chk("gap_to_next_valid", 64'(cyc - last_neg), 64'(GAP + NAC));
            pending_gap = 1'b0;
         end
         if (hold_chk && bus.o_tx_valid) begin
            chk("hold_stable", {bus.o_tx_last, bus.o_tx_data}, hold_word);
         end
         hold_chk = 1'b0;
         if (bus.o_tx_valid && !bus.i_stop) begin
            if (bus.i_tx_ready) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL sb_unexpected: got %0h required no word", {bus.o_tx_last, bus.o_tx_data});
               end else begin
                  chk("sb_word", {bus.o_tx_last, bus.o_tx_data}, exp_q.pop_front());
               end
               if (bus.o_tx_last) begin
                  last_neg    = cyc + 1;
                  pending_gap = 1'b1;
               end
            end else begin
               hold_chk  = 1'b1;
               hold_word = {bus.o_tx_last, bus.o_tx_data};
            end
         end
      end else begin
         pending_nac = 1'b0;
         pending_gap = 1'b0;
         hold_chk    = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge sd_clk);
      #1;
   endtask

   task automatic send_cmd(input logic [15:0] addr, input logic [15:0] nblk, input int exp_blks);
      logic [15:0] a;
      for (int b = 0; b < exp_blks; b++) begin
         for (int w = 0; w < WPB; w++) begin
            a = addr + 16'(b * WPB + w);
            exp_q.push_back({(w == WPB - 1), 16'h0000, a});
         end
      end
      tick(1);
      bus.i_cmd_stb  = 1'b1;
      bus.i_cmd_addr = addr;
      bus.i_cmd_nblk = nblk;
      tick(1);
      bus.i_cmd_stb  = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while (bus.o_busy && (i < budget)) begin
         tick(1);
         i++;
      end
      if (bus.o_busy) begin
         n_cmp++;
         n_err++;
         $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
      end
   endtask

   task automatic wait_hs(input int target, input int budget);
      int i = 0;
      while ((hs_count < target) && (i < budget)) begin
         tick(1);
         i++;
      end
      if (hs_count < target) begin
         n_cmp++;
         n_err++;
         $display("FAIL hs_timeout: got %0d handshakes required %0d", hs_count, target);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int d0;
      int r0;
      int h0;
      rst_n          = 1'b0;
      bus.i_cmd_stb  = 1'b0;
      bus.i_cmd_addr = '0;
      bus.i_cmd_nblk = '0;
      bus.i_stop     = 1'b0;
      tick(3);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_tx_en", bus.o_tx_en, 0);
      chk("rst_valid", bus.o_tx_valid, 0);
      chk("rst_blk_count", bus.o_blk_count, 0);
      chk("rst_mem_rd", bus.o_mem_rd, 0);
      chk("rst_state", bus.o_dbg_state, ST_IDLE);
      rst_n = 1'b1;
      tick(2);

      // single block from 0x10, tx always ready
      d0 = done_count;
      r0 = rd_count;
      send_cmd(16'h0010, 16'd1, 1);
      chk("t1_tx_en_on", bus.o_tx_en, 1);
      wait_idle(2000);
      chk("t1_blk_count", bus.o_blk_count, 1);
      chk("t1_done_pulses", 64'(done_count - d0), 1);
      chk("t1_reads", 64'(rd_count - r0), 128);
      chk("t1_queue_drained", 64'(exp_q.size()), 0);
      chk("t1_tx_en_off", bus.o_tx_en, 0);

      // three blocks with throttled ready, plus a command while busy
      throttle = 1'b1;
      d0 = done_count;
      r0 = rd_count;
      h0 = hs_count;
      send_cmd(16'h1000, 16'd3, 3);
      wait_hs(h0 + 100, 3000);
      bus.i_cmd_stb  = 1'b1;
      bus.i_cmd_addr = 16'h3000;
      bus.i_cmd_nblk = 16'd1;
      tick(1);
      bus.i_cmd_stb  = 1'b0;
      wait_idle(8000);
      throttle = 1'b0;
      chk("t2_blk_count", bus.o_blk_count, 3);
      chk("t2_done_pulses", 64'(done_count - d0), 1);
      chk("t2_reads", 64'(rd_count - r0), 384);
      chk("t2_queue_drained", 64'(exp_q.size()), 0);

      // address wrap from 0xFFFE
      d0 = done_count;
      r0 = rd_count;
      send_cmd(16'hFFFE, 16'd1, 1);
      wait_idle(2000);
      chk("t3_reads", 64'(rd_count - r0), 128);
      chk("t3_blk_count", bus.o_blk_count, 1);
      chk("t3_done_pulses", 64'(done_count - d0), 1);
      chk("t3_queue_drained", 64'(exp_q.size()), 0);
      chk("t3_end_addr", bus.o_mem_addr, 16'h007E);

      // open-ended read stopped at word 40 of block 2
      d0 = done_count;
      h0 = hs_count;
      send_cmd(16'h0100, 16'd0, 2);
      wait_hs(h0 + WPB + 40, 3000);
      bus.i_stop = 1'b1;
      tick(1);
      bus.i_stop = 1'b0;
      chk("t4_tx_en", bus.o_tx_en, 0);
      chk("t4_valid", bus.o_tx_valid, 0);
      chk("t4_done", bus.o_done, 1);
      chk("t4_busy", bus.o_busy, 0);
      chk("t4_blk_count", bus.o_blk_count, 1);
      chk("t4_words_left", 64'(exp_q.size()), 64'(2 * WPB - WPB - 40));
      exp_q.delete();
      r0 = rd_count;
      tick(20);
      chk("t4_no_reads_after_stop", 64'(rd_count - r0), 0);
      chk("t4_done_pulses", 64'(done_count - d0), 1);

      // stop together with a command in IDLE
      d0 = done_count;
      r0 = rd_count;
      bus.i_cmd_stb  = 1'b1;
      bus.i_stop     = 1'b1;
      bus.i_cmd_addr = 16'h2222;
      bus.i_cmd_nblk = 16'd1;
      tick(1);
      bus.i_cmd_stb  = 1'b0;
      bus.i_stop     = 1'b0;
      tick(10);
      chk("t5_busy", bus.o_busy, 0);
      chk("t5_reads", 64'(rd_count - r0), 0);
      chk("t5_done", 64'(done_count - d0), 0);
      chk("t5_blk_count", bus.o_blk_count, 1);

      // reset in the middle of SEND, then a clean command
      h0 = hs_count;
      send_cmd(16'h0400, 16'd1, 1);
      wait_hs(h0 + 50, 2000);
      d0 = done_count;
      rst_n = 1'b0;
      #1;
      chk("t6_busy", bus.o_busy, 0);
      chk("t6_tx_en", bus.o_tx_en, 0);
      chk("t6_valid", bus.o_tx_valid, 0);
      chk("t6_data", bus.o_tx_data, 0);
      chk("t6_last", bus.o_tx_last, 0);
      chk("t6_mem_rd", bus.o_mem_rd, 0);
      chk("t6_mem_addr", bus.o_mem_addr, 0);
      chk("t6_blk_count", bus.o_blk_count, 0);
      chk("t6_done", bus.o_done, 0);
      exp_q.delete();
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("t6_no_done_on_reset", 64'(done_count - d0), 0);
      d0 = done_count;
      send_cmd(16'h0500, 16'd2, 2);
      wait_idle(3000);
      chk("t6_blk_count_after", bus.o_blk_count, 2);
      chk("t6_done_after", 64'(done_count - d0), 1);
      chk("t6_queue_drained", 64'(exp_q.size()), 0);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
